// File: rtl/usb_host_reg_sequencer.sv
// Queues register read/write commands and replays them one at a time onto the
// USB host core register port, returning one response per command in order.
module usb_host_reg_sequencer #(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int ACK_TIMEOUT    = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] address_o,
    output logic [7:0] data_o,
    input  logic [7:0] data_i,
    output logic       we_o,
    output logic       strobe_o,
    input  logic       ack_i,
    output logic       busy
);

    localparam int PW = $clog2(CMD_FIFO_DEPTH);
    localparam logic [PW:0] FIFO_FULL = (PW+1)'(CMD_FIFO_DEPTH);
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;

    logic [16:0]   fifoMem [CMD_FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;
    logic [7:0]    ackCnt;
    logic [16:0]   head;
    logic          push;
    logic          pop;

    assign cmd_ready = (count != FIFO_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifoMem[rdPtr];
    assign busy      = (state != IDLE) || (count != '0);

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoMem[wrPtr] <= {cmd_we, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            address_o <= '0;
            data_o    <= '0;
            we_o      <= 1'b0;
            strobe_o  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ackCnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        we_o      <= head[16];
                        address_o <= head[15:8];
                        data_o    <= head[7:0];
                        strobe_o  <= 1'b1;
                        ackCnt    <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ackCnt <= ackCnt + 8'd1;
                    // An ack on the final allowed cycle still completes normally.
                    if (ack_i) begin
                        strobe_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_o ? 8'h00 : data_i;
                        state     <= RESP;
                    end else if (ackCnt == TIMEOUT_LAST) begin
                        strobe_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 8'h00;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_host_reg_sequencer.sv
// Bench for usb_host_reg_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_usb_host_reg_sequencer;

    localparam int DEPTH = 4;
    localparam int TOUT  = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] address_o;
    logic [7:0] data_o;
    logic [7:0] data_i;
    logic       we_o;
    logic       strobe_o;
    logic       ack_i;
    logic       busy;

    int nCmp = 0;
    int nBad = 0;
    int rspSeen = 0;

    usb_host_reg_sequencer #(
        .CMD_FIFO_DEPTH(DEPTH),
        .ACK_TIMEOUT(TOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .address_o(address_o),
        .data_o(data_o),
        .data_i(data_i),
        .we_o(we_o),
        .strobe_o(strobe_o),
        .ack_i(ack_i),
        .busy(busy)
    );

    always #5 clk_i = ~clk_i;

    // Transaction-level model: pending queue, one in-flight access, one held response.
    logic [16:0] mQ[$];
    logic [16:0] mCur;
    bit          mAct;
    int          mElapsed;
    bit          mRv;
    logic [7:0]  mRd;
    bit          mErr;
    bit          mValid = 0;
    bit          readyPre;

    always @(posedge clk_i) begin
        readyPre = (mQ.size() < DEPTH);
        if (rst_i) begin
            mQ.delete();
            mCur = '0;
            mAct = 0;
            mElapsed = 0;
            mRv = 0;
            mRd = '0;
            mErr = 0;
            mValid = 1;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rspSeen++;
            end
            if (mRv) begin
                if (rsp_ready) mRv = 0;
            end else if (mAct) begin
                mElapsed++;
                if (ack_i) begin
                    mAct = 0;
                    mRv = 1;
                    mErr = 0;
                    mRd = mCur[16] ? 8'h00 : data_i;
                end else if (mElapsed == TOUT) begin
                    mAct = 0;
                    mRv = 1;
                    mErr = 1;
                    mRd = 8'h00;
                end
            end else if (mQ.size() != 0) begin
                mCur = mQ.pop_front();
                mAct = 1;
                mElapsed = 0;
            end
            if (cmd_valid && readyPre) begin
                mQ.push_back({cmd_we, cmd_addr, cmd_wdata});
            end
        end
    end

    logic [28:0] expV;
    logic [28:0] gotV;

    always @(negedge clk_i) begin
        if (mValid) begin
            expV = {mQ.size() < DEPTH, mAct, mCur[16], mCur[15:8], mCur[7:0],
                    mRv, mRd, mErr, mAct || mRv || (mQ.size() != 0)};
            gotV = {cmd_ready, strobe_o, we_o, address_o, data_o,
                    rsp_valid, rsp_rdata, rsp_err, busy};
            nCmp++;
            if (gotV !== expV) begin
                nBad++;
                $display("FAIL model t=%0t got %h want %h", $time, gotV, expV);
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic sendCmd(input logic w, input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_we = w;
        cmd_addr = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            nCmp++;
            nBad++;
            $display("FAIL sendCmd: got ready=0 want ready=1 within 200 cycles");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int base;
        int ackProb;
        bit sawRv;
        rst_i = 1'b1;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        data_i = '0;
        ack_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_ready", 8'(cmd_ready), 8'h01);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_strobe", 8'(strobe_o), 8'h00);
        chk("rst_addr", address_o, 8'h00);
        chk("rst_rspv", 8'(rsp_valid), 8'h00);

        // Write with ack three cycles after strobe.
        sendCmd(1'b1, 8'h02, 8'h5A);
        chk("wr_lat_k", 8'(strobe_o), 8'h00);
        tick();
        chk("wr_strobe", 8'(strobe_o), 8'h01);
        chk("wr_addr", address_o, 8'h02);
        chk("wr_data", data_o, 8'h5A);
        chk("wr_we", 8'(we_o), 8'h01);
        tick();
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("wr_rspv", 8'(rsp_valid), 8'h01);
        chk("wr_err", 8'(rsp_err), 8'h00);
        chk("wr_rdata", rsp_rdata, 8'h00);
        chk("wr_strobe_off", 8'(strobe_o), 8'h00);
        repeat (3) tick();

        // Read returning 0xC3.
        sendCmd(1'b0, 8'h04, 8'h00);
        tick();
        data_i = 8'hC3;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("rd_rdata", rsp_rdata, 8'hC3);
        chk("rd_err", 8'(rsp_err), 8'h00);
        repeat (3) tick();

        // Timeout with ack held low; late ack in RESP must be ignored.
        rsp_ready = 1'b0;
        sendCmd(1'b0, 8'h10, 8'h00);
        tick();
        repeat (TOUT - 1) tick();
        chk("to_strobe_held", 8'(strobe_o), 8'h01);
        tick();
        chk("to_strobe_off", 8'(strobe_o), 8'h00);
        chk("to_err", 8'(rsp_err), 8'h01);
        chk("to_rdata", rsp_rdata, 8'h00);
        chk("to_rspv", 8'(rsp_valid), 8'h01);
        ack_i = 1'b1;
        data_i = 8'h77;
        tick();
        ack_i = 1'b0;
        chk("resp_ack_ignored", 8'(rsp_err), 8'h01);
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Ack on the very last allowed cycle wins over the timeout.
        sendCmd(1'b0, 8'h21, 8'h00);
        tick();
        repeat (TOUT - 1) tick();
        data_i = 8'h96;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("coinc_err", 8'(rsp_err), 8'h00);
        chk("coinc_rdata", rsp_rdata, 8'h96);
        repeat (3) tick();

        // Five commands back-to-back against a stalled response channel.
        rsp_ready = 1'b0;
        ack_i = 1'b1;
        data_i = 8'h3C;
        base = rspSeen;
        for (int i = 0; i < 5; i++) begin
            sendCmd(1'(i), 8'(8'h40 + i), 8'(8'hA0 + i));
        end
        chk("full_ready", 8'(cmd_ready), 8'h00);
        rsp_ready = 1'b1;
        repeat (40) tick();
        chk("five_rsps", 8'(rspSeen - base), 8'h05);
        ack_i = 1'b0;
        repeat (3) tick();

        // Reset mid-ISSUE with two queued commands.
        for (int i = 0; i < 3; i++) begin
            sendCmd(1'b0, 8'(8'h60 + i), 8'h00);
        end
        chk("pre_rst_strobe", 8'(strobe_o), 8'h01);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_strobe", 8'(strobe_o), 8'h00);
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_ready", 8'(cmd_ready), 8'h01);
        sawRv = 0;
        ack_i = 1'b1;
        repeat (15) begin
            tick();
            if (rsp_valid) sawRv = 1;
        end
        ack_i = 1'b0;
        chk("abort_no_rsp", 8'(sawRv), 8'h00);

        // Randomized traffic; the model compare runs every cycle.
        ackProb = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                ackProb = (i / 500) % 3 == 0 ? 0 : ((i / 500) % 3 == 1 ? 25 : 80);
            end
            cmd_valid = ($urandom_range(0, 99) < 45);
            cmd_we = 1'($urandom);
            cmd_addr = 8'($urandom);
            cmd_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 60);
            ack_i = ($urandom_range(0, 99) < ackProb);
            data_i = 8'($urandom);
            rst_i = ($urandom_range(0, 999) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        rst_i = 1'b0;
        rsp_ready = 1'b1;
        ack_i = 1'b1;
        repeat (60) tick();
        chk("drain_busy", 8'(busy), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/usb_host_reg_sequencer.md
USB_HOST_REG_SEQUENCER -- requirements
Module: usb_host_reg_sequencer

Interface
REQ-001 SHALL have parameter CMD_FIFO_DEPTH, default 4, command FIFO entries (power of 2, min 2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, max cycles in ISSUE waiting for ack (1..255).
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command FIFO can accept.
REQ-007 cmd_we  input  1  1 = register write, 0 = register read.
REQ-008 cmd_addr  input  8  target register address.
REQ-009 cmd_wdata  input  8  write data (ignored for reads).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumer accepts.
REQ-012 rsp_rdata  output  8  read data (0 for writes and errors).
REQ-013 rsp_err  output  1  access timed out.
REQ-014 address_o  output  8  to USB host core register address input.
REQ-015 data_o  output  8  to USB host core write data input.
REQ-016 data_i  input  8  from USB host core read data output.
REQ-017 we_o  output  1  to USB host core write enable.
REQ-018 strobe_o  output  1  to USB host core access strobe.
REQ-019 ack_i  input  1  from USB host core access acknowledge.
REQ-020 busy  output  1  FSM not IDLE or FIFO non-empty.

Function
REQ-021 Command accepted on rising edge where cmd_valid && cmd_ready; {cmd_we, cmd_addr, cmd_wdata} written to FIFO tail.
REQ-022 cmd_ready SHALL be 0 exactly when FIFO holds CMD_FIFO_DEPTH entries; no combinational pass-through from cmd_valid.
REQ-023 FIFO pointers wrap modulo CMD_FIFO_DEPTH; push and pop in the same cycle SHALL leave count unchanged.
REQ-024 FSM states: IDLE, ISSUE, RESP.
REQ-025 IDLE: if FIFO non-empty, pop head, register address_o/data_o/we_o, set strobe_o=1, clear timeout counter, go ISSUE; else stay.
REQ-026 Latency: command accepted at edge k into empty FIFO with FSM IDLE -> strobe_o=1 after edge k+1.
REQ-027 ISSUE: address_o, data_o, we_o, strobe_o SHALL be held stable; timeout counter increments each cycle.
REQ-028 ISSUE with ack_i=1 sampled: capture data_i into rsp_rdata if we_o=0 else 0; rsp_err=0; strobe_o=0, rsp_valid=1 next cycle; go RESP.
REQ-029 ISSUE with counter reaching ACK_TIMEOUT and ack_i=0: strobe_o=0, rsp_rdata=0, rsp_err=1, rsp_valid=1; go RESP.
REQ-030 ack_i in same cycle as timeout SHALL win (normal completion, rsp_err=0).
REQ-031 ack_i while in IDLE or RESP SHALL be ignored.
REQ-032 RESP: rsp_valid, rsp_rdata, rsp_err held until rsp_valid && rsp_ready; then rsp_valid=0, go IDLE.
REQ-033 strobe_o SHALL be low at least one cycle between consecutive accesses (RESP->IDLE->ISSUE).
REQ-034 we_o/address_o/data_o after an access SHALL retain last values; only strobe_o qualifies them.
REQ-035 Responses SHALL be returned in command order, exactly one per command.
REQ-036 Timeout counter 8 bits, no wrap past ACK_TIMEOUT.

Reset
REQ-037 rst_i=1 at an edge: FSM->IDLE, FIFO empty, strobe_o=0, we_o=0, address_o=0, data_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, busy=0; cmd_ready=1 the following cycle.
REQ-038 Reset mid-ISSUE or mid-RESP SHALL abort the access and discard pending commands and response without emitting rsp_valid.

Verification
REQ-039 Write cmd (we=1, addr=0x02, wdata=0x5A), ack_i pulse 3 cycles after strobe -> strobe_o high after edge k+1 with addr 0x02/data 0x5A/we 1, rsp_valid=1 rsp_err=0 rsp_rdata=0x00.
REQ-040 Read cmd addr 0x04, data_i=0xC3 with ack -> rsp_rdata=0xC3, rsp_err=0.
REQ-041 ACK_TIMEOUT=8, ack_i held 0 -> strobe_o drops after 8 ISSUE cycles, rsp_err=1, rsp_rdata=0.
REQ-042 Push 5 commands back-to-back with DEPTH=4, rsp_ready=0 -> cmd_ready=0 after 4th accepted while no pop yet; all 5 responses in order once rsp_ready=1; strobe_o low >=1 cycle between accesses.
REQ-043 rst_i asserted during ISSUE with 2 queued -> next cycle strobe_o=0, busy=0, no rsp_valid ever produced for aborted commands.
REQ-044 ack_i coincident with timeout cycle -> rsp_err=0, data captured.
